// File: rtl/hid_bus_master_if.sv
// Command, response and hid_* bus signals of the peripheral bus master.
// The master modport is the initiator's view; slave is the view of whoever drives commands and bus data.
interface hid_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [17:0] cmd_addr;
    logic [7:0]  cmd_be;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        hid_en;
    logic [7:0]  hid_we;
    logic [17:0] hid_addr;
    logic [63:0] hid_wrdata;
    logic [63:0] hid_rddata;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata, rsp_ready, hid_rddata,
        output cmd_ready, rsp_valid, rsp_data, hid_en, hid_we, hid_addr, hid_wrdata, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata, rsp_ready, hid_rddata,
        input  cmd_ready, rsp_valid, rsp_data, hid_en, hid_we, hid_addr, hid_wrdata, busy
    );
endinterface

// File: rtl/hid_bus_master.sv
// Single-initiator hid_* bus master: registered bus strobes, fixed-latency read capture,
// in-order response FIFO guarded by a read credit counter.
module hid_bus_master #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RESP_DEPTH = 4
) (
    input logic              msoc_clk,
    input logic              rstn,
    hid_bus_master_if.master bus
);
    localparam int unsigned PW = $clog2(RESP_DEPTH);
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

    logic [CW-1:0]     r_pending;
    logic [CW-1:0]     w_pending_next;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_next;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [63:0]       r_mem [RESP_DEPTH];
    logic [RD_LATENCY:0] r_rd_track;
    logic              r_hid_en;
    logic [7:0]        r_hid_we;
    logic [17:0]       r_hid_addr;
    logic [63:0]       r_hid_wrdata;
    logic              r_busy;

    logic w_cmd_ready;
    logic w_accept;
    logic w_rd_accept;
    logic w_push;
    logic w_pop;
    logic w_rsp_valid;

    // Credits bound reads in flight plus FIFO occupancy, so ready never looks at inputs.
    assign w_cmd_ready = (r_pending < DEPTH_C);
    assign w_accept    = bus.cmd_valid & w_cmd_ready;
    assign w_rd_accept = w_accept & ~bus.cmd_write;
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;
    // Bit 0 marks the hid_en read cycle; bit RD_LATENCY marks the cycle hid_rddata is valid.
    assign w_push      = r_rd_track[RD_LATENCY];

    always_comb begin
        w_pending_next = r_pending;
        if (w_rd_accept && !w_pop)
            w_pending_next = r_pending + CW'(1);
        else if (!w_rd_accept && w_pop)
            w_pending_next = r_pending - CW'(1);
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            r_hid_en     <= 1'b0;
            r_hid_we     <= '0;
            r_hid_addr   <= '0;
            r_hid_wrdata <= '0;
        end else if (w_accept) begin
            r_hid_en   <= 1'b1;
            r_hid_addr <= bus.cmd_addr;
            r_hid_we   <= bus.cmd_write ? bus.cmd_be : '0;
            if (bus.cmd_write)
                r_hid_wrdata <= bus.cmd_wdata;
        end else begin
            r_hid_en <= 1'b0;
            r_hid_we <= '0;
        end
    end

    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            r_rd_track <= '0;
            r_pending  <= '0;
            r_busy     <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_rd_track <= {r_rd_track[RD_LATENCY-1:0], w_rd_accept};
            r_pending  <= w_pending_next;
            r_busy     <= (w_pending_next != '0);
            r_count    <= w_count_next;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge msoc_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.hid_rddata;
    end

    ap_no_overflow: assert property (@(posedge msoc_clk) disable iff (!rstn)
        !(w_push && r_count == DEPTH_C));

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_data   = w_rsp_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.hid_en     = r_hid_en;
    assign bus.hid_we     = r_hid_we;
    assign bus.hid_addr   = r_hid_addr;
    assign bus.hid_wrdata = r_hid_wrdata;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_hid_bus_master.sv
// Bench for hid_bus_master: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model with an attached memory responder.
module tb_hid_bus_master;
    localparam int unsigned L     = 1;
    localparam int unsigned DEPTH = 4;

    logic msoc_clk = 1'b0;
    logic rstn     = 1'b0;
    always #5 msoc_clk = ~msoc_clk;

    hid_bus_master_if bus ();

    hid_bus_master #(.RD_LATENCY(L), .RESP_DEPTH(DEPTH)) dut (
        .msoc_clk (msoc_clk),
        .rstn     (rstn),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] d;
        int unsigned avail;
    } exp_t;

    exp_t        eq[$];
    logic [63:0] got[$];
    logic [63:0] model_mem[int];
    logic [63:0] resp_mem[int];
    int unsigned m_pending = 0;
    logic        m_en      = 1'b0;
    logic [7:0]  m_we      = '0;
    logic [17:0] m_addr    = '0;
    logic [63:0] m_wrdata  = '0;
    int unsigned cyc       = 0;
    bit          chk_on    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] deflt(input logic [17:0] a);
        return {a, 46'h0} ^ (64'(a) * 64'h9E37_79B9_7F4A_7C15);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int unsigned b = 0; b < 8; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Responder: a memory that answers a bus read L cycles after the hid_en cycle.
    initial begin
        logic [63:0] pipe[$];
        logic [63:0] nv;
        int          k;
        bus.hid_rddata = '0;
        for (int unsigned i = 0; i < L; i++) pipe.push_back({$urandom, $urandom});
        forever begin
            @(posedge msoc_clk);
            #1;
            nv = {$urandom, $urandom};
            k  = int'(bus.hid_addr);
            if (bus.hid_en && bus.hid_we == '0)
                nv = resp_mem.exists(k) ? resp_mem[k] : deflt(bus.hid_addr);
            else if (bus.hid_en)
                resp_mem[k] = merge(resp_mem.exists(k) ? resp_mem[k] : deflt(bus.hid_addr),
                                    bus.hid_wrdata, bus.hid_we);
            bus.hid_rddata = pipe.pop_front();
            pipe.push_back(nv);
        end
    end

    // Compare process: transaction-level model of accepted commands and returned reads.
    initial begin
        bit acc, pop, exp_valid;
        int k;
        forever begin
            @(negedge msoc_clk);
            exp_valid = (eq.size() > 0) && (eq[0].avail <= cyc);
            if (chk_on) begin
                chk("cmd_ready", bus.cmd_ready, m_pending < DEPTH);
                chk("hid_en", bus.hid_en, m_en);
                chk("hid_we", bus.hid_we, m_we);
                chk("hid_addr", bus.hid_addr, m_addr);
                chk("hid_wrdata", bus.hid_wrdata, m_wrdata);
                chk("busy", bus.busy, m_pending != 0);
                chk("rsp_valid", bus.rsp_valid, exp_valid);
                if (exp_valid) chk("rsp_data", bus.rsp_data, eq[0].d);
            end
            if (!rstn) begin
                eq.delete();
                m_pending = 0;
                m_en = 1'b0; m_we = '0; m_addr = '0; m_wrdata = '0;
                chk_on = 1'b1;
            end else if (chk_on) begin
                acc = bus.cmd_valid && (m_pending < DEPTH);
                pop = exp_valid && bus.rsp_ready;
                if (pop) begin
                    got.push_back(bus.rsp_data);
                    void'(eq.pop_front());
                    m_pending--;
                end
                m_en = acc;
                m_we = '0;
                if (acc) begin
                    k      = int'(bus.cmd_addr);
                    m_addr = bus.cmd_addr;
                    if (bus.cmd_write) begin
                        m_we       = bus.cmd_be;
                        m_wrdata   = bus.cmd_wdata;
                        model_mem[k] = merge(model_mem.exists(k) ? model_mem[k] : deflt(bus.cmd_addr),
                                             bus.cmd_wdata, bus.cmd_be);
                    end else begin
                        eq.push_back('{d: model_mem.exists(k) ? model_mem[k] : deflt(bus.cmd_addr),
                                       avail: cyc + 2 + L});
                        m_pending++;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge msoc_clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [17:0] a, input logic [7:0] be, input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_be = be; bus.cmd_wdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = bus.cmd_ready;
            step();
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (!bus.busy && !bus.rsp_valid) ok = 1'b1;
            else step();
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc_cnt, idx, hen;
        logic [17:0] a;
        model_mem[32'h1000] = 64'hDEAD_BEEF;
        resp_mem[32'h1000]  = 64'hDEAD_BEEF;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_be = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_hid_en", bus.hid_en, 0);

        // Single write
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 18'h10028;
        bus.cmd_be = 8'hFF; bus.cmd_wdata = 64'h1234;
        chk("wr_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        chk("wr_en", bus.hid_en, 1);
        chk("wr_we", bus.hid_we, 8'hFF);
        chk("wr_addr", bus.hid_addr, 18'h10028);
        chk("wr_data", bus.hid_wrdata, 64'h1234);
        step();
        chk("wr_en_drop", bus.hid_en, 0);
        chk("wr_we_drop", bus.hid_we, 0);
        chk("wr_addr_hold", bus.hid_addr, 18'h10028);
        chk("wr_no_rsp", bus.rsp_valid, 0);

        // Single read
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'h1000;
        step();
        bus.cmd_valid = 1'b0;
        chk("rd_en", bus.hid_en, 1);
        chk("rd_we", bus.hid_we, 0);
        chk("rd_wrdata_hold", bus.hid_wrdata, 64'h1234);
        step();
        chk("rd_t2_valid", bus.rsp_valid, 0);
        step();
        chk("rd_t3_valid", bus.rsp_valid, 1);
        chk("rd_t3_data", bus.rsp_data, 64'hDEAD_BEEF);
        step();
        chk("rd_busy_after_pop", bus.busy, 0);

        // Eight back-to-back reads
        wait_idle();
        got.delete();
        hen = 0;
        for (int i = 0; i < 8; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'(8 * (i + 1));
            chk("b2b_ready", bus.cmd_ready, 1);
            step();
            hen += int'(bus.hid_en);
        end
        bus.cmd_valid = 1'b0;
        step();
        chk("b2b_en_end", bus.hid_en, 0);
        chk("b2b_en_cycles", hen, 8);
        wait_idle();
        chk("b2b_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("b2b_data", got[i], deflt(18'(8 * (i + 1))));

        // Backpressure
        wait_idle();
        got.delete();
        bus.rsp_ready = 1'b0;
        acc_cnt = 0; idx = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.cmd_addr = 18'(32'h200 + 8 * idx);
            if (bus.cmd_ready) begin acc_cnt++; idx++; end
            step();
        end
        chk("bp_accepted", acc_cnt, 4);
        chk("bp_ready_low", bus.cmd_ready, 0);
        bus.cmd_addr  = 18'(32'h200 + 8 * idx);
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_ready_back", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        send(1'b0, 18'h228, 8'h00, 64'h0);
        wait_idle();
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk("bp_data", got[i], deflt(18'(32'h200 + 8 * i)));

        // Read, write, read
        got.delete();
        send(1'b0, 18'h300, 8'h00, 64'h0);
        send(1'b1, 18'h308, 8'hFF, 64'h55);
        send(1'b0, 18'h308, 8'h00, 64'h0);
        wait_idle();
        chk("mix_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("mix_first", got[0], deflt(18'h300));
            chk("mix_second", got[1], 64'h55);
        end

        // Reset with a read in flight
        got.delete();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'h400;
        step();
        bus.cmd_valid = 1'b0;
        step();
        rstn = 1'b0;
        step();
        chk("rst_en", bus.hid_en, 0);
        chk("rst_we", bus.hid_we, 0);
        chk("rst_addr", bus.hid_addr, 0);
        chk("rst_wrdata", bus.hid_wrdata, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        rstn = 1'b1;
        repeat (6) step();
        chk("rst_no_rsp", got.size(), 0);
        send(1'b0, 18'h408, 8'h00, 64'h0);
        wait_idle();
        chk("rst_new_count", got.size(), 1);
        if (got.size() == 1) chk("rst_new_data", got[0], deflt(18'h408));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            a = {3'($urandom_range(0, 7)), 12'h0, 3'($urandom_range(0, 7))} << 0;
            a = {a[17:15], 12'h0, a[2:0]} | 18'(($urandom_range(0, 7)) << 3);
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_write = ($urandom_range(0, 2) == 0);
            bus.cmd_addr  = {a[17:6], 6'(a[5:3] << 3)};
            bus.cmd_be    = 8'($urandom);
            bus.cmd_wdata = {$urandom, $urandom};
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rstn          = ($urandom_range(0, 299) != 0);
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        rstn = 1'b1;
        step();
        wait_idle();
        step();
        chk("final_drain", eq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
